// File: rtl/buceros_uart_tx_pkg.sv
// buceros_uart_tx_pkg: shared register offsets, STATUS bit positions and FSM states for the UART transmitter
//   Register offsets (addr[3:2]) and STATUS bit positions are text macros, so the bus decode and software agree on them.
//   Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
`ifndef BUCEROS_HEADER_DEFS
`define BUCEROS_HEADER_DEFS
`define UART_TXDATA_OFS 2'd0
`define UART_STATUS_OFS 2'd1
`define UART_BAUD_OFS 2'd2
`define UART_ST_FULL 2
`define UART_ST_EMPTY 3
`define UART_ST_BUSY 4
`define UART_ST_OVF 5
`define UART_ST_PAR 6
`endif

package buceros_uart_tx_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;
   localparam logic [15:0] BAUD_MIN = 16'd2;
endpackage

// File: rtl/buceros_sync_fifo.sv
// buceros_sync_fifo: first-word-fall-through synchronous FIFO
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only; contents are discarded)
//   push_i     : write din_i; accepted when not full, or when full and popping in the same cycle
//   pop_i      : drop the head entry; ignored when empty
//   dout_o     : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy flags and entry count
module buceros_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic do_push, do_pop;
   assign full_o   = count_q == (AW+1)'(DEPTH);
   assign empty_o  = count_q == '0;
   assign count_o  = count_q;
   assign dout_o   = mem_q[rd_ptr_q];
   assign do_pop   = pop_i & !empty_o;
   assign do_push  = push_i & (!full_o | do_pop);
   assign wr_ptr_d = wr_ptr_q + AW'(do_push);
   assign rd_ptr_d = rd_ptr_q + AW'(do_pop);
   assign count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/buceros_uart_tx.sv
// buceros_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, programmable baud divider and STATUS polling
//   clk, rst_n      : CPU clock, asynchronous active-low reset
//   en_i            : peripheral select; r_en_i / w_en_i : bus read / write strobes
//   addr_i          : byte address, [3:2] selects TXDATA(0) STATUS(1) BAUD(2) reserved(3)
//   w_data_i        : write data; r_data_o : combinational read data, 0 unless en_i & r_en_i
//   pin_uart_tx_o   : serial line, idle high
//   Optional feature macro: UART_PARITY_EN adds an even parity bit and sets STATUS bit6.
module buceros_uart_tx
   import buceros_uart_tx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DEFAULT_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic        r_en_i,
   input  logic        w_en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] w_data_i,
   output logic [31:0] r_data_o,
   output logic        pin_uart_tx_o
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   uart_state_e state_q, state_d;
   logic [15:0] baud_q, baud_d, period_q, period_d, cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] data_q, data_d, fifo_dout;
   logic ovf_q, ovf_d;
   logic [1:0] sel;
   logic wr, push, pop, tick, fifo_full, fifo_empty, busy, unused_ok;
   logic [CW-1:0] fifo_count;
   logic [31:0] status;
   assign sel  = addr_i[3:2];
   assign wr   = en_i & w_en_i;
   assign push = wr & (sel == `UART_TXDATA_OFS);
   assign tick = cnt_q == 16'd0;
   assign busy = state_q != ST_IDLE;
   // The head is loaded from IDLE, or straight from the last STOP cycle so frames run back to back.
   assign pop  = !fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & tick));
   assign unused_ok = ^{addr_i[31:4], addr_i[1:0], w_data_i[31:16], fifo_count};
   buceros_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (w_data_i[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );
   always_comb begin
      baud_d = (wr & (sel == `UART_BAUD_OFS)) ? ((w_data_i[15:0] < BAUD_MIN) ? BAUD_MIN : w_data_i[15:0]) : baud_q;
      // A push into a full FIFO only survives if the shifter frees a slot in the same cycle.
      ovf_d  = (push & fifo_full & !pop) | (ovf_q & !(wr & (sel == `UART_STATUS_OFS) & w_data_i[5]));
   end
   always_comb begin
      status = '0;
      status[`UART_ST_FULL]  = fifo_full;
      status[`UART_ST_EMPTY] = fifo_empty;
      status[`UART_ST_BUSY]  = busy;
      status[`UART_ST_OVF]   = ovf_q;
`ifdef UART_PARITY_EN
      status[`UART_ST_PAR]   = 1'b1;
`endif
      r_data_o = !(en_i & r_en_i) ? 32'd0 :
                 (sel == `UART_STATUS_OFS) ? status :
                 (sel == `UART_BAUD_OFS) ? {16'd0, baud_q} : 32'd0;
   end
   always_comb begin
      state_d  = state_q;
      cnt_d    = busy ? (tick ? period_q - 16'd1 : cnt_q - 16'd1) : cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      period_d = period_q;
      case (state_q)
         ST_IDLE:   state_d = fifo_empty ? ST_IDLE : ST_START;
         ST_START:  state_d = tick ? ST_DATA : ST_START;
         ST_DATA: begin
            if (tick) begin
               idx_d = idx_q + 3'd1;
`ifdef UART_PARITY_EN
               if (idx_q == 3'd7) state_d = ST_PARITY;
`else
               if (idx_q == 3'd7) state_d = ST_STOP;
`endif
            end
         end
         ST_PARITY: state_d = tick ? ST_STOP : ST_PARITY;
         ST_STOP:   state_d = tick ? (fifo_empty ? ST_IDLE : ST_START) : ST_STOP;
         default:   state_d = ST_IDLE;
      endcase
      // BAUD is frozen into period_q here so mid-frame writes only affect the next frame.
      if (pop) begin
         data_d   = fifo_dout;
         period_d = baud_q;
         cnt_d    = baud_q - 16'd1;
         idx_d    = 3'd0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= 16'(DEFAULT_DIV);
         period_q <= 16'(DEFAULT_DIV);
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
      end
   end
   assign pin_uart_tx_o = (state_q == ST_START) ? 1'b0 :
                          (state_q == ST_DATA) ? data_q[idx_q] :
                          (state_q == ST_PARITY) ? ^data_q : 1'b1;
endmodule
